// File: rtl/accumulating_add_sub_pkg.sv
// Shared definitions for the accumulating add/subtract block:
// FSM state encoding and the signed saturation limits as functions of width.
package accumulating_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Largest positive two's-complement value of the given width (width <= 64).
  function automatic logic [63:0] sat_pos_limit(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of the given width (width <= 64).
  function automatic logic [63:0] sat_neg_limit(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/accumulating_add_sub_ripple_carry_adder.sv
// Combinational ripple-carry adder: S = A + B + Cin, raw carry-out CF and
// signed overflow OF (operand signs equal, result sign differs).
module ripple_carry_adder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Cin,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  CF,
  output logic                  OF
);

  logic [DATA_WIDTH:0] carry;

  assign carry[0] = Cin;

  // One full-adder cell per bit, carry rippling from LSB to MSB.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      assign S[gi]       = A[gi] ^ B[gi] ^ carry[gi];
      assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  assign CF = carry[DATA_WIDTH];
  assign OF = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
              (S[DATA_WIDTH-1] != A[DATA_WIDTH-1]);

endmodule

// File: rtl/accumulating_add_sub.sv
// Multi-operand add/subtract accumulator. Accepts a burst of `count` signed
// operands on a valid/ready stream, folds each into a running register via
// the ripple-carry adder, then presents sum/cf/of on an output handshake.
// Optional feature macro: ACC_SATURATE_EN (saturate instead of wrapping on
// signed overflow).
module accumulating_add_sub
  import accumulating_add_sub_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cf,
  output logic                  of,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  cf_q, cf_d;
  logic                  of_q, of_d;

  logic                  load_start;
  logic                  accept;
  logic [DATA_WIDTH-1:0] add_b;
  logic                  add_cin;
  logic [DATA_WIDTH-1:0] add_s;
  logic                  add_cf;
  logic                  add_of;
  logic [DATA_WIDTH-1:0] acc_next;

  assign load_start = (state_q == ST_IDLE) && start;
  assign accept     = (state_q == ST_RUN) && in_valid;

  // Subtraction is acc + ~B + 1, so the carry-out reads as "no borrow".
  assign add_b   = in_sub ? ~in_data : in_data;
  assign add_cin = in_sub;

  ripple_carry_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_adder (
    .A  (acc_q),
    .B  (add_b),
    .Cin(add_cin),
    .CF (add_cf),
    .OF (add_of),
    .S  (add_s)
  );

`ifdef ACC_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] SAT_POS = DATA_WIDTH'(sat_pos_limit(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SAT_NEG = DATA_WIDTH'(sat_neg_limit(DATA_WIDTH));

  // Clamp toward the sign of the pre-operation accumulator on overflow.
  always_comb begin
    acc_next = add_s;
    if (add_of) begin
      acc_next = acc_q[DATA_WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end
`else
  assign acc_next = add_s;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (count != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (accept && (rem_q == CNT_WIDTH'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode the registered state only.
  always_comb begin
    in_ready  = (state_q == ST_RUN);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  // Datapath next-state: clear on burst start, fold in each accepted operand.
  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    cf_d  = cf_q;
    of_d  = of_q;
    if (load_start) begin
      acc_d = '0;
      cf_d  = 1'b0;
      of_d  = 1'b0;
      rem_d = count;
    end else if (accept) begin
      acc_d = acc_next;
      cf_d  = add_cf;
      of_d  = of_q | add_of;
      rem_d = rem_q - CNT_WIDTH'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      rem_q <= '0;
      cf_q  <= 1'b0;
      of_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      cf_q  <= cf_d;
      of_q  <= of_d;
    end
  end

  assign sum = acc_q;
  assign cf  = cf_q;
  assign of  = of_q;

endmodule

// File: tb/tb_accumulating_add_sub.sv
// Directed self-checking bench for accumulating_add_sub (8-bit data/count).
module tb_accumulating_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] count;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cf;
  logic       of;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  accumulating_add_sub #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .count    (count),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cf       (cf),
    .of       (of),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
    $display("[TB] check %-22s observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic op(input logic sub, input logic [7:0] data);
    in_valid = 1'b1;
    in_sub   = sub;
    in_data  = data;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = 8'd0; in_valid = 1'b0;
    in_data = 8'd0; in_sub = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cf", 32'(cf), 32'd0);
    chk("rst_of", 32'(of), 32'd0);

    // Mixed burst: +10 +20 -5 -> 0x19, cf=1, of=0
    start = 1'b1; count = 8'd3;
    tick();
    start = 1'b0;
    chk("mix_in_ready", 32'(in_ready), 32'd1);
    chk("mix_busy", 32'(busy), 32'd1);
    op(1'b0, 8'd10);
    chk("mix_sum_after1", 32'(sum), 32'h0A);
    chk("mix_no_outv", 32'(out_valid), 32'd0);
    op(1'b0, 8'd20);
    op(1'b1, 8'd5);
    in_valid = 1'b0;
    chk("mix_out_valid", 32'(out_valid), 32'd1);
    chk("mix_in_ready_done", 32'(in_ready), 32'd0);
    chk("mix_sum", 32'(sum), 32'h19);
    chk("mix_cf", 32'(cf), 32'd1);
    chk("mix_of", 32'(of), 32'd0);

    // Backpressure: hold out_ready low 5 cycles, pulse start mid-way
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      count = 8'd3;
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h19);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Overflow: +100 +50
    start = 1'b1; count = 8'd2;
    tick();
    start = 1'b0;
    op(1'b0, 8'd100);
    op(1'b0, 8'd50);
    in_valid = 1'b0;
    chk("ovf_out_valid", 32'(out_valid), 32'd1);
`ifdef ACC_SATURATE_EN
    chk("ovf_sum", 32'(sum), 32'h7F);
`else
    chk("ovf_sum", 32'(sum), 32'h96);
`endif
    chk("ovf_of", 32'(of), 32'd1);
    chk("ovf_cf", 32'(cf), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Zero-length burst: registers cleared, straight to DONE
    start = 1'b1; count = 8'd0;
    tick();
    start = 1'b0;
    chk("zero_out_valid", 32'(out_valid), 32'd1);
    chk("zero_in_ready", 32'(in_ready), 32'd0);
    chk("zero_sum", 32'(sum), 32'd0);
    chk("zero_cf", 32'(cf), 32'd0);
    chk("zero_of", 32'(of), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("zero_idle", 32'(busy), 32'd0);

    // Borrow: 0 - 1 -> 0xFF, cf=0 (borrow), of=0
    start = 1'b1; count = 8'd1;
    tick();
    start = 1'b0;
    op(1'b1, 8'd1);
    in_valid = 1'b0;
    chk("brw_out_valid", 32'(out_valid), 32'd1);
    chk("brw_sum", 32'(sum), 32'hFF);
    chk("brw_cf", 32'(cf), 32'd0);
    chk("brw_of", 32'(of), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Gaps: 4 x +1 with in_valid holes
    start = 1'b1; count = 8'd4;
    tick();
    start = 1'b0;
    op(1'b0, 8'd1);
    in_valid = 1'b0; tick();
    op(1'b0, 8'd1);
    in_valid = 1'b0; tick(); tick();
    chk("gap_mid_sum", 32'(sum), 32'h02);
    chk("gap_mid_in_ready", 32'(in_ready), 32'd1);
    op(1'b0, 8'd1);
    chk("gap_not_done", 32'(out_valid), 32'd0);
    op(1'b0, 8'd1);
    in_valid = 1'b0;
    chk("gap_out_valid", 32'(out_valid), 32'd1);
    chk("gap_sum", 32'(sum), 32'h04);
    chk("gap_cf", 32'(cf), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-burst after 2nd accept
    start = 1'b1; count = 8'd4;
    tick();
    start = 1'b0;
    op(1'b0, 8'd7);
    op(1'b0, 8'd7);
    chk("mrst_sum_before", 32'(sum), 32'h0E);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_sum", 32'(sum), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_outv", 32'(out_valid), 32'd0);
      chk("mrst_sum_held", 32'(sum), 32'd0);
    end
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/accumulating_add_sub.md
# accumulating_add_sub

Sequential multi-operand add/subtract accumulator built around the team's combinational adder core. It accepts a burst of `count` signed operands over a valid/ready stream and adds or subtracts each one into a running register, one operand per cycle. It then presents the final sum with carry and overflow flags on an output handshake. It sits directly downstream of the adder: it consumes the adder's `S`, `CF` and `OF` every cycle and feeds them back as the next operand A.

## Interface
- `DATA_WIDTH`, default 8: operand, accumulator and sum width (two's complement).
- `CNT_WIDTH`, default 8: width of the burst length `count`.

- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a burst; sampled only in IDLE.
- `count`, input, CNT_WIDTH: number of operands in the burst; sampled with `start`.
- `in_valid`, input, 1: operand present.
- `in_ready`, output, 1: block accepts an operand this cycle.
- `in_data`, input, DATA_WIDTH: operand B.
- `in_sub`, input, 1: 1 means acc − B, 0 means acc + B.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer takes the result.
- `sum`, output, DATA_WIDTH: accumulator value.
- `cf`, output, 1: carry-out of the last accepted operation.
- `of`, output, 1: sticky signed overflow across the burst.
- `busy`, output, 1: state is not IDLE.

## Operation
- FSM states are IDLE, RUN and DONE. All registers are in the `clk` domain.
- **Reset.** On reset, state goes to IDLE. `acc`, `remaining`, `cf` and `of` go to 0. `in_ready`, `out_valid` and `busy` go to 0.
- **IDLE**
  - `start` with `count`≠0: clear `acc`, `cf` and `of`; load `remaining`←`count`; go to RUN.
  - `start` with `count`=0: clear `acc`, `cf` and `of`; go to DONE.
- **RUN**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`:
    - Update the registers: `acc`←S, `cf`←CF, `of`←`of`|OF, `remaining`←`remaining`−1.
    - If `remaining`=1, go to DONE.
  - Cycles with `in_valid`=0 change nothing.
- **DONE**
  - `out_valid`=1; `sum`, `cf` and `of` are held stable.
  - On `out_ready`, go to IDLE.
- **Adder operands**
  - A=`acc`.
  - Add: B=`in_data`, Cin=0.
  - Subtract: B=~`in_data`, Cin=1.
  - CF is the raw carry-out. For subtraction, CF=0 means a borrow occurred.
  - OF is set when the operand signs, after inversion, match and the result sign differs.
- `start` is ignored in RUN and DONE.
- `sum` always reflects `acc`. It is meaningful to the consumer only while `out_valid`=1.

## Timing
- `start` accepted in cycle t gives `in_ready`=1 in cycle t+1.
- The block accepts one operand per cycle. The accumulator update is visible the cycle after acceptance.
- After the last operand is accepted in cycle t, `out_valid`=1 in cycle t+1.
- A `count`=0 start in cycle t gives `out_valid`=1 in cycle t+1.
- A handshake (`out_valid`&`out_ready`) in cycle t returns the block to IDLE in t+1. A new `start` can be accepted in t+1.
- The combinational path is: `acc` → adder → optional saturation mux → `acc`. There is no combinational path from inputs to `in_ready` or `out_valid`.
- **Reset mid-burst.** The burst is discarded and no `out_valid` is produced. Outputs take their reset values in the next cycle.

## Configuration
- `ACC_SATURATE_EN` defined: when an accepted operation has OF=1, `acc` saturates instead of wrapping.
  - If `acc[MSB]`=0, `acc`←2^(DATA_WIDTH−1)−1.
  - If `acc[MSB]`=1, `acc`←−2^(DATA_WIDTH−1).
  - `of` is still set and `cf` still takes the raw CF.
- Not defined: two's-complement wrap. `acc`←S unconditionally.

## Structure
- A shared package holds:
  - the FSM state encoding (IDLE, RUN, DONE);
  - the saturation-limit constant functions of DATA_WIDTH.
- Sub-module: one instance of `ripple_carry_adder` (ports `A`, `B`, `Cin`, `CF`, `OF`, `S`, parameter `DATA_WIDTH`). The operand-B inversion and the Cin select live in this block.

## Test plan
- **Mixed burst.** `count`=3; ops +10, +20, −5 with `in_valid` held high → `sum`=0x19, `cf`=1, `of`=0; `out_valid` arrives 1 cycle after the 3rd accept.
- **Overflow.** `count`=2; ops +100, +50 → without macro `sum`=0x96, `of`=1, `cf`=0; with `ACC_SATURATE_EN`, `sum`=0x7F, `of`=1.
- **Borrow.** `count`=1; op −1 (`in_sub`=1, `in_data`=1) from 0 → `sum`=0xFF, `cf`=0, `of`=0.
- **Zero-length burst.** `count`=0 → `out_valid`=1 the next cycle with `sum`=0, `cf`=0, `of`=0; `in_ready` never asserts.
- **Backpressure.** `out_ready`=0 for 5 cycles and `start` pulsed during DONE → `out_valid` and `sum` stay stable and `start` is ignored; `out_ready`=1 → IDLE in the next cycle.
- **Reset and gaps.** `in_valid` gaps inside a `count`=4 burst leave the result correct (4×+1 → 0x04); `rst` asserted after the 2nd accept → next cycle IDLE with all outputs 0 and no `out_valid`.
